timer_bank: RTL and testbench

- Parametrised successor to the free-running timer: NCHAN independent programmable down-counting timers share one clock prescaler.
- Each channel is loaded with a reload value and a mode (one-shot or periodic), then counts prescaler ticks and emits a one-cycle expire pulse.
- Used for LED blink/PWM pacing and for periodic event generation on the Fomu design.

---
 rtl/timer_bank.sv | 87 ++++++++
 tb/tb_timer_bank.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// timer_bank: NCHAN programmable down-counting one-shot/periodic timers
// sharing one free-running clock prescaler.
module timer_bank #(
    parameter int WIDTH    = 16,
    parameter int NCHAN    = 4,
    parameter int PRESCALE = 12,
    parameter int CHW      = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr_en,
    input  logic [CHW-1:0]         i_wr_chan,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_wr_periodic,
    input  logic [NCHAN-1:0]       i_stop,
    output logic                   o_tick,
    output logic [NCHAN-1:0]       o_active,
    output logic [NCHAN-1:0]       o_expire,
    output logic [NCHAN*WIDTH-1:0] o_count
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic [PW-1:0] r_pcnt;
    logic          w_tick;

    assign w_tick = (r_pcnt == PW'(PRESCALE - 1));
    assign o_tick = w_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_pcnt <= '0;
        else
            r_pcnt <= w_tick ? '0 : r_pcnt + PW'(1);
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        logic [WIDTH-1:0] r_count;
        logic [WIDTH-1:0] r_reload;
        logic             r_mode;
        logic             r_state;
        logic             r_expire;
        logic             w_load;

        // Out-of-range channel numbers never match any c < NCHAN.
        assign w_load = i_wr_en && (i_wr_chan == CHW'(c));

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_count  <= '0;
                r_reload <= '0;
                r_mode   <= 1'b0;
                r_state  <= IDLE;
                r_expire <= 1'b0;
            end else begin
                r_expire <= 1'b0;
                if (w_load) begin
                    if (i_wr_data != '0) begin
                        r_count  <= i_wr_data;
                        r_reload <= i_wr_data;
                        r_mode   <= i_wr_periodic;
                        r_state  <= RUN;
                    end else begin
                        r_count <= '0;
                        r_state <= IDLE;
                    end
                end else if (i_stop[c]) begin
                    r_count <= '0;
                    r_state <= IDLE;
                end else if (w_tick && r_state == RUN) begin
                    if (r_count > WIDTH'(1)) begin
                        r_count <= r_count - WIDTH'(1);
                    end else begin
                        r_expire <= 1'b1;
                        r_count  <= r_mode ? r_reload : '0;
                        r_state  <= r_mode ? RUN : IDLE;
                    end
                end
            end
        end

        assign o_count[c*WIDTH +: WIDTH] = r_count;
        assign o_active[c]               = r_state;
        assign o_expire[c]               = r_expire;
    end
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed stimulus with an expire-event scoreboard for timer_bank
// (WIDTH=16, NCHAN=4, PRESCALE=4, CHW=3 so channel 4 is out of range).
module tb_timer_bank;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_wr_en = 1'b0;
    logic [2:0]  i_wr_chan = '0;
    logic [15:0] i_wr_data = '0;
    logic        i_wr_periodic = 1'b0;
    logic [3:0]  i_stop = '0;
    logic        o_tick;
    logic [3:0]  o_active;
    logic [3:0]  o_expire;
    logic [63:0] o_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base = 0;
    int d;

    typedef struct {
        int          cyc;
        logic [3:0]  mask;
        logic [63:0] cnt;
    } exp_t;
    exp_t q[$];

    timer_bank #(.WIDTH(16), .NCHAN(4), .PRESCALE(4), .CHW(3)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_chan(i_wr_chan),
        .i_wr_data(i_wr_data), .i_wr_periodic(i_wr_periodic), .i_stop(i_stop),
        .o_tick(o_tick), .o_active(o_active), .o_expire(o_expire), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic wait_pcnt(input int p);
        while (((cyc - base) % 4) != p) step(1);
    endtask

    task automatic load(input int chan, input int data, input logic per);
        i_wr_en = 1'b1;
        i_wr_chan = 3'(chan);
        i_wr_data = 16'(data);
        i_wr_periodic = per;
        step(1);
        i_wr_en = 1'b0;
    endtask

    // Monitor: every expire pulse must match the head of the expected queue.
    always @(negedge i_clk) begin
        if (o_expire != 4'b0) begin
            if (q.size() == 0) begin
                chk("unexpected_expire", {60'b0, o_expire}, 64'h0);
            end else begin
                chk("expire_cycle", 64'(cyc), 64'(q[0].cyc));
                chk("expire_mask", {60'b0, o_expire}, {60'b0, q[0].mask});
                chk("expire_count", o_count, q[0].cnt);
                void'(q.pop_front());
            end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            chk("missed_expire", 64'(cyc), 64'hFFFF_FFFF);
            void'(q.pop_front());
        end
    end

    initial begin
        step(3);
        chk("reset_outputs", {o_tick, o_active, o_expire, o_count}, '0);
        i_rst_n = 1'b1;
        base = cyc;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("tick_phase", {63'b0, o_tick}, {63'b0, ((cyc - base) % 4) == 3});
            chk("idle_outputs", {o_active, o_expire, o_count}, '0);
        end

        // One-shot ch0 reload 3
        wait_pcnt(0);
        d = cyc;
        q.push_back('{d + 12, 4'b0001, 64'h0});
        load(0, 3, 1'b0);
        chk("os_load", {o_active, o_count}, {4'b0001, 64'h3});
        step(3);
        chk("os_cnt2", o_count, 64'h2);
        step(4);
        chk("os_cnt1", o_count, 64'h1);
        step(4);
        chk("os_done", {o_active, o_count}, '0);
        step(80);
        chk("os_quiet", {o_active, o_count}, '0);

        // Periodic ch1 reload 2, then stop on the count==1 tick
        wait_pcnt(0);
        d = cyc;
        q.push_back('{d + 8, 4'b0010, 64'h2_0000});
        q.push_back('{d + 16, 4'b0010, 64'h2_0000});
        q.push_back('{d + 24, 4'b0010, 64'h2_0000});
        load(1, 2, 1'b1);
        chk("per_load", {o_active, o_count}, {4'b0010, 64'h2_0000});
        step(30);
        chk("per_pre_stop", {o_tick, o_active, o_count}, {1'b1, 4'b0010, 64'h1_0000});
        i_stop = 4'b0010;
        step(1);
        i_stop = 4'b0000;
        chk("per_stopped", {o_active, o_expire, o_count}, '0);
        step(8);
        chk("per_quiet", {o_active, o_count}, '0);

        // Load during a tick cycle, zero load, out-of-range channel
        wait_pcnt(3);
        chk("tick_before_load", {63'b0, o_tick}, 64'h1);
        load(2, 5, 1'b1);
        chk("tick_load_nodec", {o_active, o_count}, {4'b0100, 64'h5_0000_0000});
        step(4);
        chk("tick_load_dec", o_count, 64'h4_0000_0000);
        load(2, 0, 1'b0);
        chk("zero_load", {o_active, o_expire, o_count}, '0);
        load(4, 7, 1'b1);
        chk("oor_chan", {o_active, o_count}, '0);
        step(8);
        chk("oor_quiet", {o_active, o_count}, '0);

        // Simultaneous expiry of ch0 and ch3
        wait_pcnt(0);
        d = cyc;
        q.push_back('{d + 4, 4'b1001, 64'h0});
        load(0, 1, 1'b0);
        load(3, 1, 1'b0);
        chk("sim_armed", {o_active, o_count}, {4'b1001, 64'h0001_0000_0000_0001});
        step(2);
        chk("sim_done", {o_active, o_count}, '0);

        // Asynchronous reset mid-count on ch1
        wait_pcnt(0);
        load(1, 3, 1'b1);
        step(5);
        chk("pre_reset", {o_active, o_count}, {4'b0010, 64'h2_0000});
        #1 i_rst_n = 1'b0;
        #1 chk("async_reset", {o_tick, o_active, o_expire, o_count}, '0);
        step(2);
        i_rst_n = 1'b1;
        base = cyc;
        step(3);
        chk("tick_after_reset", {63'b0, o_tick}, 64'h1);
        step(40);
        chk("post_reset_quiet", {o_active, o_count}, '0);
        chk("queue_empty", 64'(q.size()), 64'h0);
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
